// File: rtl/noc_pkt_pkg.sv
// Shared definitions for the multi-flit packetizer.
// Holds the packetizer FSM state type and helper functions that compute the
// flit field offsets, payload bits per flit and flit count from the parameters.
// No ports.
package noc_pkt_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // Flit layout, MSB down: head, tail, dest, vc, payload.
  function automatic int head_pos(input int width_flit);
    return width_flit - 1;
  endfunction

  function automatic int tail_pos(input int width_flit);
    return width_flit - 2;
  endfunction

  function automatic int dest_lsb(input int width_flit, input int addr_w);
    return width_flit - 2 - addr_w;
  endfunction

  function automatic int vc_lsb(input int width_flit, input int addr_w, input int vc_w);
    return width_flit - 2 - addr_w - vc_w;
  endfunction

  // The payload field sits directly below vc, so its width equals the vc LSB.
  function automatic int payload_bits(input int width_flit, input int addr_w, input int vc_w);
    return vc_lsb(width_flit, addr_w, vc_w);
  endfunction

  function automatic int num_flits(input int width_data, input int p);
    return (width_data + p - 1) / p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requesting channel at or after the pointer, wrapping.
// Ports:
//   req   - per-channel request vector
//   ptr   - index of the highest-priority channel this cycle
//   grant - one-hot grant (all zero when nothing requests)
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PtrW-1:0]   ptr,
  output logic [NUM_CH-1:0] grant
);

  logic            found;
  logic [PtrW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = PtrW'((int'(ptr) + i) % NUM_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_flit_packetizer.sv
// Multi-flit packetizer: picks one of NUM_CH request channels round-robin,
// captures its payload/dest/vc and emits it as NUM_FLITS flits with head and
// tail markers. One idle cycle separates consecutive packets.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   i_data_in    - per-channel payload
//   i_valid_in   - per-channel request
//   i_dest_in    - per-channel destination node
//   i_vc_in      - per-channel virtual channel
//   i_ready_out  - per-channel accept (only the granted channel, only while idle)
//   o_flit_out   - flit to the fabric
//   o_valid_out  - flit valid
//   o_ready_in   - fabric ready
//   o_pkt_count  - number of packets fully sent (wraps at 16 bits)
module multi_flit_packetizer
  import noc_pkt_pkg::*;
#(
  parameter int N          = 16,
  parameter int NUM_VC     = 2,
  parameter int WIDTH_DATA = 492,
  parameter int WIDTH_FLIT = 128,
  parameter int NUM_CH     = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_CH-1:0][WIDTH_DATA-1:0]       i_data_in,
  input  logic [NUM_CH-1:0]                       i_valid_in,
  input  logic [NUM_CH-1:0][$clog2(N)-1:0]        i_dest_in,
  input  logic [NUM_CH-1:0][$clog2(NUM_VC)-1:0]   i_vc_in,
  output logic [NUM_CH-1:0]                       i_ready_out,
  output logic [WIDTH_FLIT-1:0]                   o_flit_out,
  output logic                                    o_valid_out,
  input  logic                                    o_ready_in,
  output logic [15:0]                             o_pkt_count
);

  localparam int ADDRESS_WIDTH    = $clog2(N);
  localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC);
  localparam int P         = payload_bits(WIDTH_FLIT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int NUM_FLITS = num_flits(WIDTH_DATA, P);
  localparam int HeadPos   = head_pos(WIDTH_FLIT);
  localparam int TailPos   = tail_pos(WIDTH_FLIT);
  localparam int DestLsb   = dest_lsb(WIDTH_FLIT, ADDRESS_WIDTH);
  localparam int VcLsb     = vc_lsb(WIDTH_FLIT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int PadW      = NUM_FLITS * P;
  localparam int IdxW      = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int PtrW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_FLITS - 1);

  state_e                      state_q;
  logic [PtrW-1:0]             rr_ptr_q;
  logic [PtrW-1:0]             ch_q;
  logic [PtrW-1:0]             grant_idx;
  logic [PtrW-1:0]             rr_ptr_next;
  logic [IdxW-1:0]             idx_q;
  logic [WIDTH_DATA-1:0]       data_q;
  logic [ADDRESS_WIDTH-1:0]    dest_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic [NUM_CH-1:0]           grant;
  logic [PadW-1:0]             data_pad;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req   (i_valid_in),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_idx = PtrW'(i);
    end
  end

  // Reset gates the accept so no channel sees ready while reset is asserted.
  assign i_ready_out = (state_q == StIdle && !rst) ? grant : '0;

  assign rr_ptr_next = (ch_q == PtrW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

  // Flit is a pure function of the captured packet and flit index, so it stays
  // stable for as long as the fabric stalls.
  always_comb begin
    data_pad                                   = PadW'(data_q);
    o_flit_out                                 = '0;
    o_flit_out[HeadPos]                        = (idx_q == '0);
    o_flit_out[TailPos]                        = (idx_q == LastIdx);
    o_flit_out[DestLsb +: ADDRESS_WIDTH]       = dest_q;
    o_flit_out[VcLsb +: VC_ADDRESS_WIDTH]      = vc_q;
    o_flit_out[P-1:0]                          = data_pad[int'(idx_q) * P +: P];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      ch_q        <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      dest_q      <= '0;
      vc_q        <= '0;
      o_valid_out <= 1'b0;
      o_pkt_count <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            data_q      <= i_data_in[grant_idx];
            dest_q      <= i_dest_in[grant_idx];
            vc_q        <= i_vc_in[grant_idx];
            ch_q        <= grant_idx;
            idx_q       <= '0;
            o_valid_out <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (o_ready_in) begin
            if (idx_q == LastIdx) begin
              o_valid_out <= 1'b0;
              rr_ptr_q    <= rr_ptr_next;
              o_pkt_count <= o_pkt_count + 16'd1;
              state_q     <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_flit_packetizer.sv
// Self-checking bench for multi_flit_packetizer with default parameters.
// Expected flits come from the flit-format rules applied to the captured
// request; expected grants come from a first-valid-at-or-after-pointer search.
module tb_multi_flit_packetizer;

  localparam int NCH = 4;
  localparam int W   = 128;
  localparam int WD  = 492;
  localparam int AW  = 4;
  localparam int VW  = 1;
  localparam int P   = W - 2 - AW - VW;      // 121
  localparam int NF  = (WD + P - 1) / P;     // 5

  logic                    clk;
  logic                    rst;
  logic [NCH-1:0][WD-1:0]  data_in;
  logic [NCH-1:0]          valid_in;
  logic [NCH-1:0][AW-1:0]  dest_in;
  logic [NCH-1:0][VW-1:0]  vc_in;
  logic [NCH-1:0]          ready_out;
  logic [W-1:0]            flit_out;
  logic                    valid_out;
  logic                    fab_ready;
  logic [15:0]             pkt_count;

  int          errors;
  int          checks;
  int          mptr;
  logic [15:0] exp_count;
  logic [W-1:0] got [NF];
  int          hs_cyc [NF];
  int          got_n;

  multi_flit_packetizer #(
    .N          (16),
    .NUM_VC     (2),
    .WIDTH_DATA (WD),
    .WIDTH_FLIT (W),
    .NUM_CH     (NCH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data_in   (data_in),
    .i_valid_in  (valid_in),
    .i_dest_in   (dest_in),
    .i_vc_in     (vc_in),
    .i_ready_out (ready_out),
    .o_flit_out  (flit_out),
    .o_valid_out (valid_out),
    .o_ready_in  (fab_ready),
    .o_pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [WD-1:0] observed,
                     input logic [WD-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WD-1:0] rand_data();
    logic [WD-1:0] r = '0;
    for (int i = 0; i < (WD + 31) / 32; i++) r = {r[WD-33:0], $urandom()};
    return r;
  endfunction

  // Flit k: head if first, tail if last, dest, vc, then payload slice k.
  function automatic logic [W-1:0] exp_flit(input logic [WD-1:0] d, input logic [AW-1:0] dst,
                                            input logic [VW-1:0] vc, input int k);
    logic [NF*P-1:0] wide;
    wide = (NF*P)'(d) >> (k * P);
    return {(k == 0), (k == NF - 1), dst, vc, wide[P-1:0]};
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] v, input int ptr);
    for (int i = 0; i < NCH; i++) begin
      if (v[(ptr + i) % NCH]) return (ptr + i) % NCH;
    end
    return -1;
  endfunction

  task automatic wait_grant(output int ch);
    int cyc = 0;
    ch = 0;
    while (ready_out == '0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("grant_seen", WD'(ready_out != '0), WD'(1));
    chk("grant_onehot", WD'($countones(ready_out)), WD'(1));
    for (int i = 0; i < NCH; i++) if (ready_out[i]) ch = i;
  endtask

  // Drives fab_ready (0: always, 1: pattern 1,0,0, else random) and records
  // flits on each handshake until NF flits or the cycle budget runs out.
  task automatic collect(input int mode);
    int           cyc = 0;
    logic         r;
    logic         stalled = 1'b0;
    logic         seen = 1'b0;
    logic [W-1:0] held = '0;
    got_n = 0;
    while (got_n < NF && cyc < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = (($urandom() & 3) != 0);
      endcase
      fab_ready = r;
      if (valid_out) begin
        if (!seen) begin
          chk("ready_low_in_send", WD'(ready_out), '0);
          seen = 1'b1;
        end
        if (stalled) chk("stall_hold", WD'(flit_out), WD'(held));
        if (r) begin
          got[got_n]    = flit_out;
          hs_cyc[got_n] = cyc;
          got_n++;
          stalled = 1'b0;
        end else begin
          held    = flit_out;
          stalled = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    chk("handshakes", WD'(got_n), WD'(NF));
    chk("bubble_valid_low", WD'(valid_out), '0);
  endtask

  task automatic check_packet(input logic [WD-1:0] d, input logic [AW-1:0] dst,
                              input logic [VW-1:0] vc);
    logic [NF*P-1:0] re = '0;
    for (int k = 0; k < got_n; k++) begin
      chk($sformatf("flit%0d", k), WD'(got[k]), WD'(exp_flit(d, dst, vc, k)));
      re |= (NF*P)'(got[k][P-1:0]) << (k * P);
    end
    chk("reassembled", WD'(re[WD-1:0]), d);
    chk("pad_zero", WD'(re[NF*P-1:WD]), '0);
  endtask

  task automatic send_one(input int ch, input logic [WD-1:0] d, input logic [AW-1:0] dst,
                          input logic [VW-1:0] vc, input int mode);
    int g;
    data_in[ch]  = d;
    dest_in[ch]  = dst;
    vc_in[ch]    = vc;
    valid_in[ch] = 1'b1;
    #1;
    wait_grant(g);
    chk("grant_ch", WD'(g), WD'(model_grant(valid_in, mptr)));
    tick();
    valid_in[ch] = 1'b0;
    collect(mode);
    check_packet(d, dst, vc);
    mptr = (g + 1) % NCH;
    exp_count++;
    chk("pkt_count", WD'(pkt_count), WD'(exp_count));
  endtask

  initial begin
    int            g;
    logic [WD-1:0] sd;
    logic [AW-1:0] sdst;
    logic [VW-1:0] svc;

    errors    = 0;
    checks    = 0;
    mptr      = 0;
    exp_count = '0;
    got_n     = 0;
    rst       = 1'b1;
    data_in   = '0;
    dest_in   = '0;
    vc_in     = '0;
    fab_ready = 1'b0;
    valid_in  = '1;  // requests present during reset must not be accepted

    // Reset state
    repeat (3) tick();
    chk("rst_valid", WD'(valid_out), '0);
    chk("rst_count", WD'(pkt_count), '0);
    chk("rst_ready", WD'(ready_out), '0);
    valid_in = '0;
    rst      = 1'b0;
    tick();
    chk("idle_no_valid", WD'(valid_out), '0);

    // Single packet, fabric always ready
    send_one(0, WD'(3), 4'd15, 1'b1, 0);
    chk("consecutive", WD'(hs_cyc[NF-1] - hs_cyc[0]), WD'(NF - 1));
    chk("head_bits", WD'({got[4][W-1], got[3][W-1], got[2][W-1], got[1][W-1], got[0][W-1]}),
        WD'(5'b00001));
    chk("tail_bits", WD'({got[4][W-2], got[3][W-2], got[2][W-2], got[1][W-2], got[0][W-2]}),
        WD'(5'b10000));
    chk("flit0_payload", WD'(got[0][P-1:0]), WD'(3));

    // Backpressure 1,0,0 repeating
    send_one(2, rand_data(), 4'($urandom()), 1'($urandom()), 1);

    // Fairness from a fresh reset with all channels requesting
    rst = 1'b1;
    #1;
    rst = 1'b0;
    mptr      = 0;
    exp_count = '0;
    tick();
    chk("fair_count_reset", WD'(pkt_count), '0);
    for (int c = 0; c < NCH; c++) begin
      data_in[c] = rand_data();
      dest_in[c] = 4'($urandom());
      vc_in[c]   = 1'($urandom());
    end
    valid_in = '1;
    #1;
    for (int i = 0; i < 8; i++) begin
      wait_grant(g);
      chk("fair_model", WD'(g), WD'(model_grant(valid_in, mptr)));
      chk("fair_order", WD'(g), WD'(i % NCH));
      sd   = data_in[g];
      sdst = dest_in[g];
      svc  = vc_in[g];
      tick();
      data_in[g] = rand_data();
      dest_in[g] = 4'($urandom());
      vc_in[g]   = 1'($urandom());
      collect(2);
      check_packet(sd, sdst, svc);
      mptr = (g + 1) % NCH;
      exp_count++;
      chk("fair_count", WD'(pkt_count), WD'(exp_count));
    end

    // Random request subsets; non-granted requests may come and go
    for (int i = 0; i < 12; i++) begin
      valid_in = 4'($urandom_range(1, 15));
      for (int c = 0; c < NCH; c++) begin
        data_in[c] = rand_data();
        dest_in[c] = 4'($urandom());
        vc_in[c]   = 1'($urandom());
      end
      #1;
      wait_grant(g);
      chk("rand_grant", WD'(g), WD'(model_grant(valid_in, mptr)));
      sd   = data_in[g];
      sdst = dest_in[g];
      svc  = vc_in[g];
      tick();
      collect(2);
      check_packet(sd, sdst, svc);
      mptr = (g + 1) % NCH;
      exp_count++;
      chk("rand_count", WD'(pkt_count), WD'(exp_count));
    end
    valid_in = '0;
    #1;

    // Top data bit lands in bit 7 of the last flit, rest of that flit zero
    sd      = '0;
    sd[491] = 1'b1;
    send_one(3, sd, 4'd9, 1'b0, 0);
    chk("last_bit7", WD'(got[4][7]), WD'(1));
    chk("last_hi_zero", WD'(got[4][P-1:8]), '0);

    // Reset in the middle of a packet
    data_in[1]  = rand_data();
    valid_in[1] = 1'b1;
    #1;
    wait_grant(g);
    tick();
    valid_in  = '0;
    fab_ready = 1'b1;
    repeat (3) tick();
    chk("mid_valid", WD'(valid_out), WD'(1));
    chk("mid_count", WD'(pkt_count), WD'(exp_count));
    valid_in = 4'b0010;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", WD'(valid_out), '0);
    chk("arst_count", WD'(pkt_count), '0);
    chk("arst_ready", WD'(ready_out), '0);
    valid_in = '0;
    #2;
    rst       = 1'b0;
    mptr      = 0;
    exp_count = '0;
    send_one(1, rand_data(), 4'd5, 1'b1, 0);
    chk("post_rst_head", WD'(got[0][W-1]), WD'(1));

    // Counter wrap: preload to the last value, one more packet reads zero
    force dut.o_pkt_count = 16'hffff;
    #1;
    release dut.o_pkt_count;
    #1;
    chk("preload", WD'(pkt_count), WD'(16'hffff));
    exp_count = 16'hffff;
    send_one(0, rand_data(), 4'd1, 1'b0, 2);
    chk("wrap_zero", WD'(pkt_count), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
